// File: rtl/serial_ring_store.sv
// Serial bit ring with word-aligned parallel read port.
// Optional SERIAL_RING_CLEAR_EN adds a synchronous clr input.
module serial_ring_store #(
   parameter int ADDRESS_WIDTH = 4,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
`ifdef SERIAL_RING_CLEAR_EN
   input  logic                     clr,
`endif
   input  logic                     ser_en,
   input  logic                     ser_in,
   output logic                     ser_out,
   output logic                     aligned,
   output logic [ADDRESS_WIDTH-1:0] word_ofs,
   input  logic                     rd_req,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic                     rd_busy,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_valid
);

   localparam int DEPTH = 2 ** ADDRESS_WIDTH;
   localparam int N     = DEPTH * DATA_WIDTH;
   localparam int CW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic {IDLE, PEND} state_t;

   logic [N-1:0]             ring_q, ring_d;
   logic [CW-1:0]            bcnt_q, bcnt_d;
   logic [ADDRESS_WIDTH-1:0] ofs_q, ofs_d;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [ADDRESS_WIDTH-1:0] sel_addr;
   logic [ADDRESS_WIDTH-1:0] phys;
   logic [DATA_WIDTH-1:0]    word;
   logic [DATA_WIDTH-1:0]    rd_data_q;
   logic                     rd_valid_q;
   logic                     clr_w;
   logic                     wrap;
   logic                     can_serve;
   state_t                   state_q;

`ifdef SERIAL_RING_CLEAR_EN
   assign clr_w = clr;
`else
   assign clr_w = 1'b0;
`endif

   assign wrap      = (bcnt_q == CW'(DATA_WIDTH - 1));
   assign aligned   = (bcnt_q == '0);
   assign can_serve = aligned & ~ser_en;
   assign ser_out   = ring_q[0];
   assign word_ofs  = ofs_q;
   assign rd_busy   = (state_q == PEND);
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;

   always_comb begin
      ring_d = ring_q;
      bcnt_d = bcnt_q;
      ofs_d  = ofs_q;
      unique case (1'b1)
         clr_w: begin
            ring_d = '0;
            bcnt_d = '0;
            ofs_d  = '0;
         end
         ser_en: begin
            ring_d = {ser_in, ring_q[N-1:1]};
            bcnt_d = wrap ? '0 : bcnt_q + CW'(1);
            ofs_d  = wrap ? ofs_q + ADDRESS_WIDTH'(1) : ofs_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ring_q <= '0;
         bcnt_q <= '0;
         ofs_q  <= '0;
      end else begin
         ring_q <= ring_d;
         bcnt_q <= bcnt_d;
         ofs_q  <= ofs_d;
      end
   end

   // Absolute address rotates with the ring; map to physical slot.
   assign sel_addr = (state_q == PEND) ? addr_q : rd_addr;
   assign phys     = sel_addr - ofs_q;

   always_comb begin
      word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (phys == ADDRESS_WIDTH'(i))
            word = ring_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         if (clr_w) begin
            state_q <= IDLE;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (rd_req) begin
                     if (can_serve) begin
                        rd_data_q  <= word;
                        rd_valid_q <= 1'b1;
                     end else begin
                        addr_q  <= rd_addr;
                        state_q <= PEND;
                     end
                  end
               end
               PEND: begin
                  if (can_serve) begin
                     rd_data_q  <= word;
                     rd_valid_q <= 1'b1;
                     state_q    <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_ring_store.sv
// Directed bench for serial_ring_store (DATA_WIDTH=8, ADDRESS_WIDTH=4).
// Exercises SERIAL_RING_CLEAR_EN when that macro is defined.
module tb_serial_ring_store;

   logic       clk;
   logic       rst_n;
   logic       ser_en;
   logic       ser_in;
   logic       ser_out;
   logic       aligned;
   logic [3:0] word_ofs;
   logic       rd_req;
   logic [3:0] rd_addr;
   logic       rd_busy;
   logic [7:0] rd_data;
   logic       rd_valid;
`ifdef SERIAL_RING_CLEAR_EN
   logic       clr;
`endif

   int errs;
   int checks;

   serial_ring_store #(
      .ADDRESS_WIDTH(4),
      .DATA_WIDTH   (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
`ifdef SERIAL_RING_CLEAR_EN
      .clr     (clr),
`endif
      .ser_en  (ser_en),
      .ser_in  (ser_in),
      .ser_out (ser_out),
      .aligned (aligned),
      .word_ofs(word_ofs),
      .rd_req  (rd_req),
      .rd_addr (rd_addr),
      .rd_busy (rd_busy),
      .rd_data (rd_data),
      .rd_valid(rd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_word(input logic [7:0] w, output logic [7:0] o);
      for (int i = 0; i < 8; i++) begin
         ser_en = 1'b1;
         ser_in = w[i];
         o[i]   = ser_out;
         step();
      end
      ser_en = 1'b0;
      ser_in = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [3:0] a,
                          input logic [7:0] exp);
      rd_req  = 1'b1;
      rd_addr = a;
      step();
      chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, "_data"}, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] o;
      logic [7:0] acc;
      int         seen;
      int         lat;
      errs    = 0;
      checks  = 0;
      rst_n   = 1'b0;
      ser_en  = 1'b0;
      ser_in  = 1'b0;
      rd_req  = 1'b0;
      rd_addr = '0;
`ifdef SERIAL_RING_CLEAR_EN
      clr     = 1'b0;
`endif
      step();
      step();
      rst_n = 1'b1;
      step();

      chk("rst_ser_out", 32'(ser_out), 32'd0);
      chk("rst_aligned", 32'(aligned), 32'd1);
      chk("rst_word_ofs", 32'(word_ofs), 32'd0);
      chk("rst_busy", 32'(rd_busy), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);

      // Immediate read after reset
      do_read("r029", 4'd5, 8'h00);
      chk("r029_busy", 32'(rd_busy), 32'd0);
      rd_req = 1'b0;
      step();
      chk("r029_pulse", 32'(rd_valid), 32'd0);

      // Fill the ring: word k = 0x10+k
      acc = '0;
      for (int k = 0; k < 16; k++) begin
         shift_word(8'(8'h10 + k), o);
         acc = acc | o;
      end
      chk("fill_out_zero", 32'(acc), 32'd0);
      chk("fill_ofs", 32'(word_ofs), 32'd0);
      chk("fill_aligned", 32'(aligned), 32'd1);
      do_read("r030", 4'd3, 8'h13);
      rd_req = 1'b0;
      step();
      chk("r030_pulse", 32'(rd_valid), 32'd0);

      // One more word rotates the ring by one slot
      shift_word(8'hAA, o);
      chk("r031_out", 32'(o), 32'h10);
      chk("r031_ofs", 32'(word_ofs), 32'd1);
      do_read("r031_a0", 4'd0, 8'hAA);
      do_read("r031_a1", 4'd1, 8'h11);
      do_read("r031_a9", 4'd9, 8'h19);
      rd_req = 1'b0;
      step();
      chk("r031_pulse", 32'(rd_valid), 32'd0);

      // Read issued mid-word is deferred to the next boundary
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] w;
         w       = 8'hC3;
         ser_en  = 1'b1;
         ser_in  = w[i];
         o[i]    = ser_out;
         rd_req  = (i == 3) || (i == 4);
         rd_addr = (i == 4) ? 4'd7 : 4'd2;
         step();
         if (rd_valid) seen++;
         if (i == 3) chk("r032_busy", 32'(rd_busy), 32'd1);
      end
      ser_en = 1'b0;
      rd_req = 1'b0;
      chk("r032_out", 32'(o), 32'h11);
      chk("r032_no_early", 32'(seen), 32'd0);
      chk("r032_busy_hold", 32'(rd_busy), 32'd1);
      chk("r032_ofs", 32'(word_ofs), 32'd2);
      lat = 0;
      while (!rd_valid && lat < 4) begin
         step();
         lat++;
      end
      chk("r032_latency", 32'(lat), 32'd1);
      chk("r032_data", 32'(rd_data), 32'h12);
      chk("r032_idle", 32'(rd_busy), 32'd0);
      do_read("r032_a1", 4'd1, 8'hC3);
      rd_req = 1'b0;
      step();

      // Async reset mid-word with a pending read
      for (int i = 0; i < 5; i++) begin
         ser_en = 1'b1;
         ser_in = 1'b1;
         rd_req = (i == 1);
         rd_addr = 4'd4;
         step();
      end
      chk("r033_mid_aligned", 32'(aligned), 32'd0);
      chk("r033_pend", 32'(rd_busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("r033_busy", 32'(rd_busy), 32'd0);
      chk("r033_aligned", 32'(aligned), 32'd1);
      chk("r033_ofs", 32'(word_ofs), 32'd0);
      chk("r033_ser_out", 32'(ser_out), 32'd0);
      chk("r033_rd_data", 32'(rd_data), 32'd0);
      ser_en = 1'b0;
      rd_req = 1'b0;
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (rd_valid) seen++;
      end
      chk("r033_no_valid", 32'(seen), 32'd0);
      do_read("r033_a4", 4'd4, 8'h00);
      rd_req = 1'b0;
      step();

`ifdef SERIAL_RING_CLEAR_EN
      shift_word(8'h5A, o);
      do_read("clr_pre", 4'd0, 8'h5A);
      rd_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ser_en  = 1'b1;
         ser_in  = 1'b1;
         rd_req  = (i == 0);
         rd_addr = 4'd0;
         step();
      end
      chk("clr_pend", 32'(rd_busy), 32'd1);
      clr    = 1'b1;
      rd_req = 1'b1;
      step();
      clr    = 1'b0;
      ser_en = 1'b0;
      rd_req = 1'b0;
      chk("clr_busy", 32'(rd_busy), 32'd0);
      chk("clr_ofs", 32'(word_ofs), 32'd0);
      chk("clr_aligned", 32'(aligned), 32'd1);
      chk("clr_valid", 32'(rd_valid), 32'd0);
      chk("clr_ser_out", 32'(ser_out), 32'd0);
      chk("clr_data_hold", 32'(rd_data), 32'h5A);
      step();
      chk("clr_no_valid", 32'(rd_valid), 32'd0);
      do_read("clr_a0", 4'd0, 8'h00);
      rd_req = 1'b0;
      step();
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
